// File: rtl/bridge_rdata_fifo_if.sv
// ---------------------------------------------------------------------------
// bridge_rdata_fifo_if
// Bundles the OBI read-beat input, the register-block control strobes and the
// FIFO status outputs of bridge_rdata_fifo.
//   slave  : the FIFO side (takes beats/strobes, drives data and status)
//   master : the bridge / register-block side
// Signals:
//   obi_rvalid_i, obi_rdata_i : read beat from the OBI bridge
//   pop_i, clear_i            : consume head word / flush, from register block
//   rdata_o                   : head word (valid while empty_o is 0)
//   empty_o, full_o, count_o  : occupancy
//   overflow_o, underflow_o   : sticky error flags
// ---------------------------------------------------------------------------
interface bridge_rdata_fifo_if #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH_LOG2 = 4
);
    logic                   obi_rvalid_i;
    logic [pDATA_WIDTH-1:0] obi_rdata_i;
    logic                   pop_i;
    logic                   clear_i;
    logic [pDATA_WIDTH-1:0] rdata_o;
    logic                   empty_o;
    logic                   full_o;
    logic [pDEPTH_LOG2:0]   count_o;
    logic                   overflow_o;
    logic                   underflow_o;

    modport master (
        output obi_rvalid_i, obi_rdata_i, pop_i, clear_i,
        input  rdata_o, empty_o, full_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  obi_rvalid_i, obi_rdata_i, pop_i, clear_i,
        output rdata_o, empty_o, full_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/bridge_rdata_fifo.sv
// ---------------------------------------------------------------------------
// bridge_rdata_fifo
// First-word-fall-through buffer for OBI read-data beats returned by the
// bridge. The host drains it one word per register read via pop_i.
// Ports:
//   clk     : single clock domain (HEEP clock)
//   reset_i : synchronous, active-high reset
//   bus     : bridge_rdata_fifo_if.slave (beats, pop/clear, data, status)
// Array contents are never reset; only pointers, count and flags are.
// ---------------------------------------------------------------------------
module bridge_rdata_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              reset_i,
    bridge_rdata_fifo_if.slave bus
);
    localparam int                     lpDEPTH    = 1 << pDEPTH_LOG2;
    localparam logic [pDEPTH_LOG2:0]   lpFULL     = lpDEPTH[pDEPTH_LOG2:0];
    localparam logic [pDEPTH_LOG2:0]   lpCNT_ONE  = 1;
    localparam logic [pDEPTH_LOG2-1:0] lpPTR_ONE  = 1;

    logic [pDATA_WIDTH-1:0] r_mem [lpDEPTH];
    logic [pDEPTH_LOG2-1:0] r_wptr;
    logic [pDEPTH_LOG2-1:0] r_rptr;
    logic [pDEPTH_LOG2:0]   r_count;
    logic                   r_overflow;
    logic                   r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_under;

    assign w_full  = (r_count == lpFULL);
    assign w_empty = (r_count == '0);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = bus.obi_rvalid_i && (!w_full || bus.pop_i);
    assign w_pop   = bus.pop_i && !w_empty;
    assign w_drop  = bus.obi_rvalid_i && w_full && !bus.pop_i;
    assign w_under = bus.pop_i && w_empty;

    // Storage: no reset. When full with a concurrent pop, wptr == rptr; the
    // head is read combinationally before the edge overwrites that slot.
    always_ff @(posedge clk) begin
        if (w_push && !bus.clear_i && !reset_i) begin
            r_mem[r_wptr] <= bus.obi_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i || bus.clear_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + lpPTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + lpPTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + lpCNT_ONE;
                2'b01:   r_count <= r_count - lpCNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop)  r_overflow  <= 1'b1;
            if (w_under) r_underflow <= 1'b1;
        end
    end

    assign bus.rdata_o     = r_mem[r_rptr];
    assign bus.empty_o     = w_empty;
    assign bus.full_o      = w_full;
    assign bus.count_o     = r_count;
    assign bus.overflow_o  = r_overflow;
    assign bus.underflow_o = r_underflow;
endmodule
